// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing generator with registered sync/DE outputs and a
// prefetch request stream that leads DE by PREFETCH enabled clocks.
module video_timing_gen #(
    parameter int H_ACTIVE = 480,
    parameter int H_FP     = 8,
    parameter int H_SYNC   = 4,
    parameter int H_BP     = 43,
    parameter int V_ACTIVE = 272,
    parameter int V_FP     = 8,
    parameter int V_SYNC   = 4,
    parameter int V_BP     = 12,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int PREFETCH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [10:0] x,
    output logic [10:0] y,
    output logic        line_start,
    output logic        frame_start,
    output logic        pix_req,
    output logic [10:0] req_x,
    output logic [10:0] req_y
);
    localparam logic [11:0] HA    = 12'(H_ACTIVE);
    localparam logic [11:0] HT_M1 = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [11:0] HT    = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam logic [11:0] HS0   = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS1   = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] VA    = 12'(V_ACTIVE);
    localparam logic [11:0] VT_M1 = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [11:0] VS0   = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS1   = 12'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [11:0] PF    = 12'(PREFETCH);

    logic [11:0] h_q, h_d, v_q, v_d, v_nx, h_pf, hp, vp;
    logic        h_wrap, de_q, de_d, ls_q, ls_d, fs_q, fs_d, hs_q, hs_d, vs_q, vs_d, rq_q, rq_d;
    logic [10:0] x_q, x_d, y_q, y_d, rx_q, rx_d, ry_q, ry_d;

    always_comb begin
        h_wrap = h_q == HT_M1;
        v_nx   = (v_q == VT_M1) ? 12'd0 : v_q + 12'd1;
        h_d    = en ? (h_wrap ? 12'd0 : h_q + 12'd1) : h_q;
        v_d    = (en && h_wrap) ? v_nx : v_q;
        h_pf   = h_q + PF;
        hp     = (h_pf >= HT) ? h_pf - HT : h_pf;
        vp     = (h_pf >= HT) ? v_nx : v_q;
    end

    // Outputs decode the pre-edge counters; a stalled clock zeroes the strobes and holds the rest.
    always_comb begin
        de_d = en && (h_q < HA) && (v_q < VA);
        x_d  = de_d ? h_q[10:0] : x_q;
        y_d  = de_d ? v_q[10:0] : y_q;
        ls_d = en && (h_q == 12'd0) && (v_q < VA);
        fs_d = en && (h_q == 12'd0) && (v_q == 12'd0);
        hs_d = en ? ((h_q >= HS0 && h_q < HS1) ? HS_POL : !HS_POL) : hs_q;
        vs_d = en ? ((v_q >= VS0 && v_q < VS1) ? VS_POL : !VS_POL) : vs_q;
        rq_d = en && (hp < HA) && (vp < VA);
        rx_d = rq_d ? hp[10:0] : rx_q;
        ry_d = rq_d ? vp[10:0] : ry_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q  <= '0;
            v_q  <= '0;
            de_q <= 1'b0;
            ls_q <= 1'b0;
            fs_q <= 1'b0;
            rq_q <= 1'b0;
            x_q  <= '0;
            y_q  <= '0;
            rx_q <= '0;
            ry_q <= '0;
            hs_q <= !HS_POL;
            vs_q <= !VS_POL;
        end else begin
            h_q  <= h_d;
            v_q  <= v_d;
            de_q <= de_d;
            ls_q <= ls_d;
            fs_q <= fs_d;
            rq_q <= rq_d;
            x_q  <= x_d;
            y_q  <= y_d;
            rx_q <= rx_d;
            ry_q <= ry_d;
            hs_q <= hs_d;
            vs_q <= vs_d;
        end
    end

    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign de          = de_q;
    assign x           = x_q;
    assign y           = y_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;
    assign pix_req     = rq_q;
    assign req_x       = rx_q;
    assign req_y       = ry_q;
endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: reduced-geometry raster checked against a linear pixel-index model
// plus a request/display queue that verifies the prefetch lead.
module tb_video_timing_gen;
    localparam int HA = 16, HF = 3, HS = 2, HB = 4;
    localparam int VA = 6, VF = 2, VS = 2, VB = 2;
    localparam int PF = 3;
    localparam bit HP = 1'b0, VP = 1'b1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int TOT = HT * VT;

    logic clk = 1'b0, rst_n = 1'b1, en = 1'b0;
    logic hsync, vsync, de, line_start, frame_start, pix_req;
    logic [10:0] x, y, req_x, req_y;

    int total = 0, bad = 0;
    int p = 0, en_cnt = 0, skip = PF;
    int n_fs = 0, n_de = 0, n_ls = 0;
    logic m_de, m_ls, m_fs, m_req, m_hs, m_vs;
    int mx, my, rx, ry;
    int qx[$], qy[$], qt[$];

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(HP), .VS_POL(VP), .PREFETCH(PF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .hsync(hsync), .vsync(vsync), .de(de), .x(x), .y(y),
        .line_start(line_start), .frame_start(frame_start),
        .pix_req(pix_req), .req_x(req_x), .req_y(req_y)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h p=%0d", tag, obs, exp, p);
        end
    endtask

    task automatic check_all();
        check("de", 32'(de), 32'(m_de));
        check("line_start", 32'(line_start), 32'(m_ls));
        check("frame_start", 32'(frame_start), 32'(m_fs));
        check("pix_req", 32'(pix_req), 32'(m_req));
        check("hsync", 32'(hsync), 32'(m_hs));
        check("vsync", 32'(vsync), 32'(m_vs));
        check("x", 32'(x), 32'(mx));
        check("y", 32'(y), 32'(my));
        check("req_x", 32'(req_x), 32'(rx));
        check("req_y", 32'(req_y), 32'(ry));
    endtask

    task automatic model_reset();
        p = 0; skip = PF;
        m_de = 0; m_ls = 0; m_fs = 0; m_req = 0;
        mx = 0; my = 0; rx = 0; ry = 0;
        m_hs = !HP; m_vs = !VP;
        qx.delete(); qy.delete(); qt.delete();
    endtask

    task automatic step(input logic e);
        int h, v, q;
        en = e;
        @(posedge clk);
        #1;
        h = p % HT; v = p / HT;
        if (e) begin
            m_de = (h < HA) && (v < VA);
            if (m_de) begin mx = h; my = v; end
            m_ls = (h == 0) && (v < VA);
            m_fs = (p == 0);
            m_hs = (h >= HA + HF && h < HA + HF + HS) ? HP : !HP;
            m_vs = (v >= VA + VF && v < VA + VF + VS) ? VP : !VP;
            q = (p + PF) % TOT;
            m_req = (q % HT < HA) && (q / HT < VA);
            if (m_req) begin rx = q % HT; ry = q / HT; end
            p = (p + 1) % TOT;
            en_cnt++;
        end else begin
            m_de = 0; m_ls = 0; m_fs = 0; m_req = 0;
        end
        check_all();
        if (de === 1'b1) begin
            if (skip > 0) skip--;
            else begin
                check("req_pending", 32'(qx.size() > 0), 32'd1);
                if (qx.size() > 0) begin
                    check("req_match_x", 32'(x), 32'(qx.pop_front()));
                    check("req_match_y", 32'(y), 32'(qy.pop_front()));
                    check("req_lead", 32'(en_cnt - qt.pop_front()), 32'(PF));
                end
            end
        end
        if (pix_req === 1'b1) begin
            qx.push_back(int'(req_x)); qy.push_back(int'(req_y)); qt.push_back(en_cnt);
        end
        n_fs += int'(frame_start === 1'b1);
        n_de += int'(de === 1'b1);
        n_ls += int'(line_start === 1'b1);
    endtask

    task automatic seek(input int target);
        for (int i = 0; i < TOT && p != target; i++) step(1'b1);
        check("seek", 32'(p), 32'(target));
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #11;
        model_reset();
        check_all();
        rst_n = 1'b1;
        // three free-running frames from reset
        n_fs = 0; n_de = 0; n_ls = 0;
        for (int i = 0; i < 3 * TOT; i++) step(1'b1);
        check("frames", 32'(n_fs), 32'd3);
        check("de_count", 32'(n_de), 32'(3 * HA * VA));
        check("ls_count", 32'(n_ls), 32'(3 * VA));
        // random enable pattern
        for (int i = 0; i < 1500; i++) step($urandom_range(0, 9) != 0);
        // stall mid-line at x=10, y=3
        seek(3 * HT + 10);
        for (int i = 0; i < 7; i++) step(1'b0);
        step(1'b1);
        check("resume_x", 32'(x), 32'd10);
        // stall on the last clock of the frame
        seek(TOT - 1);
        for (int i = 0; i < 7; i++) step(1'b0);
        n_fs = 0;
        step(1'b1);
        step(1'b1);
        check("wrap_fs", 32'(frame_start), 32'd1);
        for (int i = 0; i < 10; i++) step(1'b1);
        check("wrap_fs_once", 32'(n_fs), 32'd1);
        // asynchronous reset mid-frame at x=12, y=2
        seek(2 * HT + 12);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
        step(1'b1);
        check("rst_fs", 32'(frame_start), 32'd1);
        check("rst_x0", 32'(x), 32'd0);
        for (int i = 0; i < 1200; i++) step($urandom_range(0, 4) != 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, default 480, visible pixels per line.
REQ-002 Parameter H_FP, default 8, horizontal front porch in clocks.
REQ-003 Parameter H_SYNC, default 4, hsync width in clocks.
REQ-004 Parameter H_BP, default 43, horizontal back porch in clocks; H_TOTAL = 535.
REQ-005 Parameter V_ACTIVE, default 272, visible lines per frame.
REQ-006 Parameter V_FP, default 8, vertical front porch in lines.
REQ-007 Parameter V_SYNC, default 4, vsync width in lines.
REQ-008 Parameter V_BP, default 12, vertical back porch in lines; V_TOTAL = 296.
REQ-009 Parameter HS_POL, default 0, hsync active level; VS_POL, default 0, vsync active level.
REQ-010 Parameter PREFETCH, default 2, pixel-request lead in enabled clocks; legal range 1..(H_FP+H_SYNC+H_BP).
REQ-011 Port clk, input, 1, pixel clock from the on-chip PLL clkout; all logic on its rising edge.
REQ-012 Port rst_n, input, 1, asynchronous active-low reset.
REQ-013 Port en, input, 1, timing advance enable.
REQ-014 Port hsync, output, 1, horizontal sync, level per HS_POL.
REQ-015 Port vsync, output, 1, vertical sync, level per VS_POL.
REQ-016 Port de, output, 1, data enable, high on visible pixels.
REQ-017 Port x, output, 11, visible pixel column, valid when de=1.
REQ-018 Port y, output, 11, visible pixel row, valid when de=1.
REQ-019 Port line_start, output, 1, one-clock pulse on first pixel of each visible line.
REQ-020 Port frame_start, output, 1, one-clock pulse on pixel (0,0).
REQ-021 Port pix_req, output, 1, fetch request for pixel (req_x, req_y), PREFETCH enabled clocks ahead of its de.
REQ-022 Ports req_x, req_y, output, 11 each, coordinates of requested pixel.

Function
REQ-023 Internal counters h_cnt 0..H_TOTAL-1 and v_cnt 0..V_TOTAL-1; order within each axis: active, front porch, sync, back porch.
REQ-024 With en=1, h_cnt increments each clock; at H_TOTAL-1 wraps to 0 and v_cnt increments; v_cnt at V_TOTAL-1 with h wrap returns to 0.
REQ-025 All outputs registered; each clock they decode the pre-edge counter value (latency 1 clock from counter to pins).
REQ-026 de = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE); x = h_cnt, y = v_cnt when de, else x, y hold last value.
REQ-027 hsync active while H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, every line including blanking lines.
REQ-028 vsync active while V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC; changes only together with h_cnt=0.
REQ-029 line_start = (h_cnt==0) && (v_cnt < V_ACTIVE); frame_start = (h_cnt==0) && (v_cnt==0).
REQ-030 Lookahead: hp = h_cnt+PREFETCH, vp = v_cnt; if hp >= H_TOTAL then hp -= H_TOTAL and vp = (v_cnt+1) mod V_TOTAL.
REQ-031 pix_req = (hp < H_ACTIVE) && (vp < V_ACTIVE); req_x = hp, req_y = vp when pix_req, else hold.
REQ-032 Every pix_req for (X,Y) precedes de for (X,Y) by exactly PREFETCH enabled clocks, including across line and frame wrap.
REQ-033 en=0: counters hold; de, pix_req, line_start, frame_start driven 0; hsync, vsync, x, y, req_x, req_y hold.
REQ-034 en re-asserted: sequence resumes from held counter position with no skipped or repeated pixel.
REQ-035 Counter arithmetic in 12 bits internally to avoid overflow of hp; outputs truncated to 11 bits.

Reset
REQ-036 rst_n low asynchronously sets h_cnt=0, v_cnt=0, de=0, pix_req=0, line_start=0, frame_start=0, x=y=req_x=req_y=0, hsync=!HS_POL, vsync=!VS_POL.
REQ-037 Reset asserted mid-frame aborts the frame; first enabled edge after release produces frame_start=1, de=1, x=0, y=0.

Verification
REQ-038 Reset release, en=1 constant -> frame_start every 158360 clocks, de high 130560 clocks per frame, line_start 272 per frame.
REQ-039 Defaults, line 0 -> de 480 clocks at x=0..479, hsync low for clocks 488..491 after line_start, period 535.
REQ-040 Defaults -> vsync low during lines 280..283, edges coincident with h_cnt=0 decode, 4*535=2140 clocks wide.
REQ-041 PREFETCH=2 -> pix_req (0,0) at clocks 533,534 relative to last frame line start of line 295 wrap; every req precedes matching de by 2 clocks; req (0,1) occurs during line 0 blanking.
REQ-042 en toggled low 7 clocks at x=100 and at h_cnt=534,v_cnt=295 -> outputs de/pulses 0 during stall, resume with x=100 and frame_start exactly once, no pixel lost.
REQ-043 rst_n pulsed low at (x=200,y=50) -> outputs reach reset values immediately without clock; after release frame_start at first enabled edge.
